rd_exec_ctrl: RTL and testbench
===============================

# rd_exec_ctrl

Instruction fetch/execute sequencer that acts as the initiator for the register-file port (RA/rd read, res_dest/enact writeback) and the ALU mode input. It fetches an 8-bit instruction addressed by its own program counter, reads the operand registers, drives the ALU and writes the result back. It replaces manual key/switch control of the register file in the command read-execute experiment.

## Interface
- No parameters; all widths fixed at 8-bit data, 2-bit register address.
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = execute instructions, 0 = stop after the current instruction
- step  in  1  single-step request pulse (used only with SINGLE_STEP_EN)
- instr  in  8  instruction memory data at address PC (combinational read)
- x_in  in  8  register-file read data for register RA while rd=1 (combinational)
- alu_res  in  8  ALU result for alu_a/alu_b/alu_m (combinational)
- PC  out  8  program counter
- RA  out  2  register-file read address
- rd  out  1  register-file read strobe
- res_dest  out  2  writeback register index
- enact  out  1  writeback strobe, one cycle
- res_out  out  8  writeback data, valid while enact=1
- alu_a, alu_b  out  8  ALU operands
- alu_m  out  2  ALU function select
- busy  out  1  1 in any state except IDLE and HALT
- halted  out  1  1 in HALT

## Operation
- Instruction format: [7:6] class, [5:4] ALU function, [3:2] Rd, [1:0] Rs.
- Classes: 00 NOP, 01 ALU (Rd <- Rd op Rs), 10 MOV (Rd <- Rs), 11 HALT.
- Internal registers: IR, A, B, RES (8 bits each), state.
- States and transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: IR <- instr; PC <- PC+1. Next depends on instr[7:6]: 01 -> RD_A, 10 -> RD_B, 11 -> HALT, 00 -> END.
  - RD_A: RA=IR[3:2], rd=1; A <- x_in; -> RD_B.
  - RD_B: RA=IR[1:0], rd=1; B <- x_in; ALU -> EXEC, MOV -> WB with RES <- x_in.
  - EXEC: alu_a=A, alu_b=B, alu_m=IR[5:4]; RES <- alu_res; -> WB.
  - WB: res_dest=IR[3:2], enact=1, res_out=RES; -> END.
  - END (combinational decision, not a state): run=1 -> FETCH, else IDLE.
  - HALT: absorbing; only clr_n leaves it.
- rd=0 and enact=0 in every other state. RA, res_dest, alu_m hold 0 when not asserted; alu_a/alu_b reflect A/B at all times.
- PC arithmetic mod 256: 8'hFF increments to 8'h00, no flag.
- Clearing run mid-instruction never aborts it; the instruction completes, including WB, before IDLE.
- Rd=Rs is legal; both reads return the same register value.

## Timing
- Reset (clr_n=0, asynchronous): state IDLE; PC, IR, A, B, RES = 8'h00; all outputs 0. Takes effect immediately, including mid-instruction; a pending writeback is dropped (enact falls at once).
- Latency from FETCH entry, run held at 1: ALU 5 cycles, MOV 3 cycles, NOP 1 cycle, HALT 1 cycle to halted=1.
- Back-to-back instructions with no idle cycle while run=1.
- enact is exactly one cycle wide per ALU/MOV instruction; the register file writes on that edge.
- x_in and alu_res are sampled on the rising edge that ends RD_A/RD_B and EXEC respectively.

## Configuration
- SINGLE_STEP_EN defined: END goes to IDLE unconditionally. IDLE -> FETCH requires run=1 and step=1 on the same edge. Exactly one instruction executes per step pulse. A step held high executes one instruction per pass through IDLE.
- SINGLE_STEP_EN undefined: step is ignored; behaviour as in Operation.

## Test plan
- Reset with R0=8'h05, R1=8'h03. Program: 0x41 (ALU, fn 00=add, Rd=R0, Rs=R1), run=1. Required: RA=0 then RA=1 with rd=1, alu_a=05, alu_b=03, then enact=1, res_dest=0, res_out=alu_res. PC=1 after FETCH. Whole instruction is 5 cycles.
- MOV 0x86 (Rd=R1, Rs=R2) with R2=8'hA5. Required: single read cycle RA=2, then enact with res_dest=1, res_out=A5. 3 cycles total.
- Program 00,00,C0 (NOP, NOP, HALT). Required: halted=1 on cycle 3, PC=3, busy=0. PC frozen with run still 1.
- PC=8'hFF with a NOP at that address. Required: PC wraps to 8'h00 and fetch continues from address 0.
- run drops during RD_A of an ALU instruction. Required: instruction completes (enact pulses once), then IDLE with busy=0. Assert clr_n=0 during EXEC of the next instruction: all outputs 0 immediately, no enact.
- SINGLE_STEP_EN with run=1: no fetch until step. Each step pulse executes exactly one instruction (one enact per ALU/MOV), then returns to IDLE.

Source files
------------

// File: rtl/rd_exec_ctrl.sv
// Fetch/execute sequencer driving register-file reads, the ALU and writeback.
// Optional SINGLE_STEP_EN: one instruction per step pulse, then back to IDLE.
module rd_exec_ctrl (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] instr,
    input  logic [7:0] x_in,
    input  logic [7:0] alu_res,
    output logic [7:0] PC,
    output logic [1:0] RA,
    output logic       rd,
    output logic [1:0] res_dest,
    output logic       enact,
    output logic [7:0] res_out,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_m,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_RD_A, S_RD_B, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [1:0] C_ALU  = 2'b01;
    localparam logic [1:0] C_MOV  = 2'b10;
    localparam logic [1:0] C_HALT = 2'b11;

    state_t     state_q, state_d, end_st;
    logic [7:0] pc_q, pc_d, ir_q, ir_d;
    logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0] ra_q, ra_d, dest_q, dest_d, m_q, m_d;
    logic       rd_q, rd_d, en_q, en_d;
    logic       busy_q, busy_d, halt_q, halt_d;
    logic       go;

`ifdef SINGLE_STEP_EN
    assign go     = run & step;
    assign end_st = S_IDLE;
`else
    logic step_unused;
    assign step_unused = step;
    assign go     = run;
    assign end_st = run ? S_FETCH : S_IDLE;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_FETCH;
            S_FETCH: begin
                ir_d = instr;
                pc_d = pc_q + 8'd1;
                case (instr[7:6])
                    C_ALU:   state_d = S_RD_A;
                    C_MOV:   state_d = S_RD_B;
                    C_HALT:  state_d = S_HALT;
                    default: state_d = end_st;
                endcase
            end
            S_RD_A: begin
                a_d     = x_in;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                b_d = x_in;
                if (ir_q[7:6] == C_MOV) begin
                    res_d   = x_in;
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                state_d = S_WB;
            end
            S_WB:    state_d = end_st;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register alongside it.
    always_comb begin
        ra_d   = 2'd0;
        rd_d   = 1'b0;
        m_d    = 2'd0;
        dest_d = 2'd0;
        en_d   = 1'b0;
        case (state_d)
            S_RD_A: begin
                ra_d = ir_d[3:2];
                rd_d = 1'b1;
            end
            S_RD_B: begin
                ra_d = ir_d[1:0];
                rd_d = 1'b1;
            end
            S_EXEC: m_d = ir_d[5:4];
            S_WB: begin
                dest_d = ir_d[3:2];
                en_d   = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
        halt_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 8'h00;
            ra_q    <= 2'd0;
            rd_q    <= 1'b0;
            m_q     <= 2'd0;
            dest_q  <= 2'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ra_q    <= ra_d;
            rd_q    <= rd_d;
            m_q     <= m_d;
            dest_q  <= dest_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            halt_q  <= halt_d;
        end
    end

    assign PC       = pc_q;
    assign RA       = ra_q;
    assign rd       = rd_q;
    assign res_dest = dest_q;
    assign enact    = en_q;
    assign res_out  = res_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_m    = m_q;
    assign busy     = busy_q;
    assign halted   = halt_q;

endmodule

// File: tb/tb_rd_exec_ctrl.sv
// Bench for rd_exec_ctrl: instruction-level model plus per-cycle compare.
// Environment: instruction memory, 4-entry register file and a small ALU.
module tb_rd_exec_ctrl;

    logic       clk, clr_n, run, step;
    logic [7:0] instr, x_in, alu_res;
    logic [7:0] PC, res_out, alu_a, alu_b;
    logic [1:0] RA, res_dest, alu_m;
    logic       rd, enact, busy, halted;

    logic [7:0] imem [256];
    logic [7:0] rf [4];
    logic [7:0] rf_init [4];
    int vectors = 0;
    int miscompares = 0;
    int enact_cnt = 0;
    int e0;

    rd_exec_ctrl dut (
        .clk(clk), .clr_n(clr_n), .run(run), .step(step),
        .instr(instr), .x_in(x_in), .alu_res(alu_res),
        .PC(PC), .RA(RA), .rd(rd), .res_dest(res_dest),
        .enact(enact), .res_out(res_out), .alu_a(alu_a),
        .alu_b(alu_b), .alu_m(alu_m), .busy(busy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                         logic [1:0] m);
        case (m)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign instr   = imem[PC];
    assign x_in    = rd ? rf[RA] : 8'h5A;
    assign alu_res = alu_f(alu_a, alu_b, alu_m);

    always @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
        end else if (enact) begin
            rf[res_dest] <= res_out;
            enact_cnt++;
        end
    end

    typedef struct packed {
        logic [7:0] pc;
        logic [1:0] ra;
        logic       rd;
        logic [1:0] dst;
        logic       en;
        logic [7:0] res;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] m;
        logic       busy;
        logic       halted;
    } obs_t;

    obs_t       q[$];
    obs_t       cur;
    logic [7:0] mpc, ma, mb, wd;
    logic [7:0] mreg [4];
    logic [1:0] wi;
    bit         mhalt, hpend, wv, start;

    function automatic obs_t base();
        obs_t r;
        r    = '0;
        r.pc = mpc;
        r.a  = ma;
        r.b  = mb;
        return r;
    endfunction

    // One instruction expands into its full list of visible cycles.
    task automatic gen();
        obs_t       r;
        logic [7:0] i, res;
        logic [1:0] d, s, fn;
        i  = imem[mpc];
        fn = i[5:4];
        d  = i[3:2];
        s  = i[1:0];
        r = base(); r.busy = 1'b1; q.push_back(r);
        mpc = mpc + 8'd1;
        case (i[7:6])
            2'b01: begin
                r = base(); r.busy = 1; r.ra = d; r.rd = 1; q.push_back(r);
                ma = mreg[d];
                r = base(); r.busy = 1; r.ra = s; r.rd = 1; q.push_back(r);
                mb = mreg[s];
                r = base(); r.busy = 1; r.m = fn; q.push_back(r);
                res = alu_f(ma, mb, fn);
                r = base(); r.busy = 1; r.dst = d; r.en = 1; r.res = res;
                q.push_back(r);
                wv = 1; wi = d; wd = res;
            end
            2'b10: begin
                r = base(); r.busy = 1; r.ra = s; r.rd = 1; q.push_back(r);
                mb = mreg[s];
                r = base(); r.busy = 1; r.dst = d; r.en = 1; r.res = mb;
                q.push_back(r);
                wv = 1; wi = d; wd = mb;
            end
            2'b11: hpend = 1;
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q.delete();
            mpc = 0; ma = 0; mb = 0;
            mhalt = 0; hpend = 0; wv = 0;
            for (int i = 0; i < 4; i++) mreg[i] = rf_init[i];
            cur = base();
        end else begin
            if (cur.en && wv) begin
                mreg[wi] = wd;
                wv = 0;
            end
`ifdef SINGLE_STEP_EN
            start = !cur.busy && run && step;
`else
            start = run;
`endif
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (hpend || mhalt) begin
                mhalt = 1; hpend = 0;
                cur = base(); cur.halted = 1;
            end else if (start) begin
                gen();
                cur = q.pop_front();
            end else begin
                cur = base();
            end
        end
    end

    function automatic string fmt(obs_t o);
        return $sformatf("pc=%h ra=%0d rd=%0d dst=%0d en=%0d res=%h a=%h b=%h m=%0d busy=%0d halt=%0d",
            o.pc, o.ra, o.rd, o.dst, o.en, o.res, o.a, o.b, o.m, o.busy, o.halted);
    endfunction

    always @(negedge clk) begin
        obs_t act, exp;
        act = '{PC, RA, rd, res_dest, enact, res_out, alu_a, alu_b,
                alu_m, busy, halted};
        exp = cur;
        if (!exp.en) begin
            act.res = 8'h00;
            exp.res = 8'h00;
        end
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle t=%0t got {%s} want {%s}", $time,
                     fmt(act), fmt(exp));
        end
    end

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wn(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setup(logic [7:0] r0, logic [7:0] r1, logic [7:0] r2);
        @(negedge clk);
        clr_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        rf_init[0] = r0; rf_init[1] = r1;
        rf_init[2] = r2; rf_init[3] = 8'h00;
        wn(2);
        clr_n = 1'b1;
        e0 = enact_cnt;
    endtask

    initial begin
        clr_n = 1'b0; run = 1'b0; step = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 4; i++) rf_init[i] = 8'h00;
        wn(1);
        chk("reset_pc", PC, 0);
        chk("reset_busy", busy, 0);
        chk("reset_enact", enact, 0);
`ifndef SINGLE_STEP_EN
        setup(8'h05, 8'h03, 8'hA5);
        imem[0] = 8'h41; imem[1] = 8'hC0;
        run = 1'b1;
        wn(1); chk("alu_fetch_busy", busy, 1); chk("alu_fetch_pc", PC, 0);
        wn(1); chk("alu_rda_ra", RA, 0); chk("alu_rda_rd", rd, 1);
        chk("alu_pc1", PC, 1);
        wn(1); chk("alu_rdb_ra", RA, 1); chk("alu_rdb_a", alu_a, 8'h05);
        wn(1); chk("alu_exec_b", alu_b, 8'h03); chk("alu_exec_rd", rd, 0);
        wn(1); chk("alu_wb_en", enact, 1); chk("alu_wb_dst", res_dest, 0);
        chk("alu_wb_res", res_out, 8'h08);
        wn(1); chk("alu_rf0", rf[0], 8'h08); chk("alu_en_off", enact, 0);
        wn(1); chk("alu_halt", halted, 1);

        setup(8'h05, 8'h03, 8'hA5);
        imem[0] = 8'h86; imem[1] = 8'hC0;
        run = 1'b1;
        wn(2); chk("mov_ra", RA, 2); chk("mov_rd", rd, 1);
        wn(1); chk("mov_en", enact, 1); chk("mov_dst", res_dest, 1);
        chk("mov_res", res_out, 8'hA5);
        wn(1); chk("mov_rf1", rf[1], 8'hA5);

        setup(8'h00, 8'h00, 8'h00);
        imem[2] = 8'hC0;
        run = 1'b1; step = 1'b1;
        wn(3); chk("nop_pc", PC, 2);
        wn(1); chk("halt_flag", halted, 1); chk("halt_pc", PC, 3);
        chk("halt_busy", busy, 0);
        wn(5); chk("halt_frozen", PC, 3);

        setup(8'h00, 8'h00, 8'h77);
        run = 1'b1;
        wn(2);
        imem[0] = 8'h86;
        wn(254); chk("wrap_ff", PC, 8'hFF);
        wn(1); chk("wrap_00", PC, 8'h00);
        wn(1); chk("wrap_ra", RA, 2); chk("wrap_rd", rd, 1);
        run = 1'b0;
        wn(3); chk("wrap_idle", busy, 0);

        setup(8'h05, 8'h03, 8'h00);
        imem[0] = 8'h41; imem[1] = 8'h41;
        run = 1'b1;
        wn(2);
        run = 1'b0;
        wn(3); chk("drop_en", enact, 1); chk("drop_res", res_out, 8'h08);
        wn(1); chk("drop_idle", busy, 0); chk("drop_rf0", rf[0], 8'h08);
        chk("drop_once", enact_cnt - e0, 1);
        wn(2); chk("drop_pc", PC, 1);
        run = 1'b1;
        wn(4); chk("exec2_a", alu_a, 8'h08); chk("exec2_b", alu_b, 8'h03);
        #2 clr_n = 1'b0;
        #1;
        chk("rst_en", enact, 0); chk("rst_busy", busy, 0);
        chk("rst_pc", PC, 0); chk("rst_a", alu_a, 0);
        chk("rst_rd", rd, 0);
        wn(3); chk("rst_no_wb", enact_cnt - e0, 1);
        clr_n = 1'b1;
        run = 1'b0;
        wn(2);
`else
        setup(8'h05, 8'h03, 8'hA5);
        imem[0] = 8'h41; imem[1] = 8'h86; imem[3] = 8'hC0;
        run = 1'b1;
        wn(4); chk("ss_wait_busy", busy, 0); chk("ss_wait_pc", PC, 0);
        step = 1'b1;
        wn(1); step = 1'b0; chk("ss_go", busy, 1);
        wn(5); chk("ss1_idle", busy, 0); chk("ss1_pc", PC, 1);
        chk("ss1_rf0", rf[0], 8'h08); chk("ss1_en", enact_cnt - e0, 1);
        wn(2); chk("ss1_hold", PC, 1);
        step = 1'b1;
        wn(1); step = 1'b0;
        wn(3); chk("ss2_idle", busy, 0); chk("ss2_pc", PC, 2);
        chk("ss2_en", enact_cnt - e0, 2);
        step = 1'b1;
        wn(6); step = 1'b0;
        wn(2); chk("ss_halt", halted, 1); chk("ss_halt_pc", PC, 4);
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
